// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request collector.
// The client count is fixed at 4 to match the arbiter request width.
package rr_pkg;

   localparam int NUM_CLIENTS = 4;
   localparam int IDX_W       = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      GRANT = 2'd2,
      SEND  = 2'd3
   } collector_state_t;

   function automatic logic [NUM_CLIENTS-1:0] onehot4(input logic [IDX_W-1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_request_collector_if.sv
// Client, arbiter and downstream signals of the request collector.
// slave is the collector's view; master is the surrounding environment.
interface rr_request_collector_if #(
   parameter int DATA_W = 8
);
   import rr_pkg::*;

   logic [NUM_CLIENTS-1:0]        client_valid;
   logic [NUM_CLIENTS*DATA_W-1:0] client_data;
   logic [NUM_CLIENTS-1:0]        client_ready;
   logic [NUM_CLIENTS-1:0]        arb_requests;
   logic                          arb_enable;
   logic [NUM_CLIENTS-1:0]        arb_grant;
   logic [IDX_W-1:0]              arb_index;
   logic                          out_valid;
   logic [DATA_W-1:0]             out_data;
   logic [IDX_W-1:0]              out_index;
   logic                          out_ready;
   logic                          err_grant;

   modport slave (
      input  client_valid, client_data, arb_grant, arb_index, out_ready,
      output client_ready, arb_requests, arb_enable, out_valid, out_data,
             out_index, err_grant
   );

   modport master (
      output client_valid, client_data, arb_grant, arb_index, out_ready,
      input  client_ready, arb_requests, arb_enable, out_valid, out_data,
             out_index, err_grant
   );

endinterface

// File: rtl/rr_hold_slot.sv
// One client's holding register: loads on valid & ready, clears on downstream handshake.
// Pending is visible the cycle after the load; ready stays low while pending.
module rr_hold_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_vld,
   input  logic [DATA_W-1:0] load_dat,
   input  logic              clr,
   output logic [DATA_W-1:0] hold_dat,
   output logic              pending,
   output logic              ready
);

   logic [DATA_W-1:0] hold_q, hold_d;
   logic              pending_q, pending_d;

   // clr only arrives while pending, so it never coincides with a load
   always_comb begin
      hold_d    = hold_q;
      pending_d = pending_q;
      if (load_vld && !pending_q) begin
         hold_d    = load_dat;
         pending_d = 1'b1;
      end else if (clr) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         pending_q <= pending_d;
      end
   end

   assign hold_dat = hold_q;
   assign pending  = pending_q;
   assign ready    = ~pending_q;

endmodule

// File: rtl/rr_request_collector.sv
// Collects one payload per client, runs IDLE/ARB/GRANT/SEND against an external RR arbiter.
// Load to out_valid is 4 edges; out_data/out_index hold while out_valid & ~out_ready.
module rr_request_collector
   import rr_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   rr_request_collector_if.slave  bus
);

   logic [NUM_CLIENTS-1:0] pending;
   logic [NUM_CLIENTS-1:0] ready;
   logic [NUM_CLIENTS-1:0] load;
   logic [NUM_CLIENTS-1:0] clr;
   logic [DATA_W-1:0]      hold_dat [NUM_CLIENTS];

   collector_state_t  state_q, state_d;
   logic [IDX_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              err_grant_q, err_grant_d;
   logic              arb_enable;
   logic              grant_ok;

   for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_slot
      rr_hold_slot #(.DATA_W(DATA_W)) u_slot (
         .clk      (clk),
         .reset    (reset),
         .load_vld (bus.client_valid[i]),
         .load_dat (bus.client_data[i*DATA_W +: DATA_W]),
         .clr      (clr[i]),
         .hold_dat (hold_dat[i]),
         .pending  (pending[i]),
         .ready    (ready[i])
      );
   end

   assign load = bus.client_valid & ready;

   // a one-hot grant equal to 1<<index, naming a client that actually has a request
   assign grant_ok = (bus.arb_grant == onehot4(bus.arb_index)) && pending[bus.arb_index];

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      out_data_d  = out_data_q;
      err_grant_d = err_grant_q;
      clr         = '0;
      arb_enable  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pending) state_d = ARB;
         end
         ARB: begin
            arb_enable = 1'b1;
            state_d    = GRANT;
         end
         GRANT: begin
            if (grant_ok) begin
               sel_d      = bus.arb_index;
               out_data_d = hold_dat[bus.arb_index];
               state_d    = SEND;
            end else begin
               err_grant_d = 1'b1;
               state_d     = IDLE;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               clr = onehot4(sel_q);
               // same-cycle loads from other clients keep the pipeline busy without an IDLE bubble
               if (|((pending | load) & ~onehot4(sel_q))) state_d = ARB;
               else                                        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         out_data_q  <= '0;
         err_grant_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         out_data_q  <= out_data_d;
         err_grant_q <= err_grant_d;
      end
   end

   assign bus.client_ready = ready;
   assign bus.arb_requests = pending;
   assign bus.arb_enable   = arb_enable;
   assign bus.out_valid    = (state_q == SEND);
   assign bus.out_data     = out_data_q;
   assign bus.out_index    = sel_q;
   assign bus.err_grant    = err_grant_q;

endmodule
